serial_subtractor: RTL and testbench

- Multi-cycle, bit-serial WIDTH-bit subtractor. Computes Diff = A - B - Bin one bit per clock, LSB first, with a single borrow flip-flop.
- Counterpart of the combinational hybrid adder in the arithmetic lab set. It covers the inverse operation with a start/done handshake, so it can sit behind a simple controller or a self-checking bench.
- Produces the borrow-out, signed overflow and zero flags.

---
 rtl/serial_subtractor.sv | 154 +++++++++++++++
 tb/tb_serial_subtractor.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: Diff = A - B - Bin, one bit per clock,
// LSB first, with a single borrow flip-flop and a start/done handshake.
// Result flags (Bout, V, Z) and Diff hold until the next completion edge.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             V,
  output logic             Z,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;       // minuend shift register
  logic [WIDTH-1:0] b_q, b_d;       // subtrahend shift register
  logic [WIDTH-1:0] res_q, res_d;   // result assembled MSB-in
  logic             br_q, br_d;     // running borrow
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d; // operand signs kept for the overflow flag
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             v_q, v_d;
  logic             z_q, z_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Per-bit full-subtractor terms
  logic             a0, b0, dbit, br_nxt, last;
  logic [WIDTH-1:0] res_shift;

  assign a0        = a_q[0];
  assign b0        = b_q[0];
  assign dbit      = a0 ^ b0 ^ br_q;
  assign br_nxt    = (~a0 & b0) | (~(a0 ^ b0) & br_q);
  assign res_shift = {dbit, res_q[WIDTH-1:1]};
  assign last      = (cnt_q == CW'(WIDTH-1));

  // Next-state and datapath update; every register holds by default
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    v_d     = v_q;
    z_d     = z_q;
    busy_d  = busy_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          br_d    = Bin;
          cnt_d   = '0;
          a_msb_d = A[WIDTH-1];
          b_msb_d = B[WIDTH-1];
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        res_d = res_shift;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_nxt;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          diff_d  = res_shift;
          bout_d  = br_nxt;
          v_d     = (a_msb_q != b_msb_q) && (res_shift[WIDTH-1] != a_msb_q);
          z_d     = (res_shift == '0);
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      v_q     <= v_d;
      z_q     <= z_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Diff = diff_q;
  assign Bout = bout_q;
  assign V    = v_q;
  assign Z    = z_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: vector table, back-to-back start,
// mid-operation reset and an operand sweep against a word-level model.
module tb_serial_subtractor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A, B;
  logic         Bin;
  logic [W-1:0] Diff;
  logic         Bout, V, Z, busy, done;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Bin(Bin),
    .Diff(Diff), .Bout(Bout), .V(V), .Z(Z), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
    logic         v;
    logic         z;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Word-level reference: {Bout, V, Z, Diff}
  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic bin);
    logic [W:0]   t;
    logic [W-1:0] d;
    logic         v;
    t = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    d = t[W-1:0];
    v = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
    return {t[W], v, (d == '0), d};
  endfunction

  // One full operation; operands are scrambled right after acceptance
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int lat;
    bit got;
    @(negedge clk);
    A = a; B = b; Bin = bin; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = ~a; B = ~b; Bin = ~bin;
    chk("busy_after_accept", busy, 1);
    lat = 0; got = 0;
    for (int i = 1; i <= W + 4 && !got; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1; lat = i;
        chk("busy_at_done", busy, 0);
      end else if (i < W) begin
        if (busy !== 1'b1) chk("busy_during_shift", busy, 1);
      end
    end
    chk("latency", lat, W);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
  endtask

  task automatic chk_res(input string nm, input logic [W+2:0] exp);
    chk({nm, "_diff"}, Diff, exp[W-1:0]);
    chk({nm, "_bout"}, Bout, exp[W+2]);
    chk({nm, "_v"}, V, exp[W+1]);
    chk({nm, "_z"}, Z, exp[W]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] ea[3], eb[3];
    logic         ebin[3];
    logic [W-1:0] sa, sb;
    logic         sbin;
    bit           seen;

    tbl[0] = '{8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'h20, 8'h50, 1'b0, 8'hD0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{8'h07, 8'h06, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    #12;
    chk("rst_diff", Diff, 0);
    chk("rst_flags", {Bout, V, Z, busy, done}, 0);
    @(negedge clk); rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 7; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].bin);
      chk($sformatf("vec%0d_diff", i), Diff, tbl[i].d);
      chk($sformatf("vec%0d_bout", i), Bout, tbl[i].bo);
      chk($sformatf("vec%0d_v", i), V, tbl[i].v);
      chk($sformatf("vec%0d_z", i), Z, tbl[i].z);
    end

    // Start held high with operands changing every cycle
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (n > 0) chk($sformatf("held_done_n%0d", n), done, (n % 10 == 9));
      if (n % 10 == 9)
        chk_res($sformatf("held_op%0d", n / 10), model(ea[n/10], eb[n/10], ebin[n/10]));
      A = W'(n * 13 + 5); B = W'(n * 29 + 3); Bin = n[0]; start = 1'b1;
      if (n % 10 == 0) begin ea[n/10] = A; eb[n/10] = B; ebin[n/10] = Bin; end
    end
    @(negedge clk); start = 1'b0;
    chk("held_done_n30", done, 0);

    // Reset in the middle of an operation
    do_op(8'h50, 8'h20, 1'b0);
    @(negedge clk); A = 8'h55; B = 8'h11; Bin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_diff", Diff, 0);
    chk("midrst_flags", {Bout, V, Z, busy, done}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    chk("midrst_no_done", seen, 0);
    chk("midrst_hold_diff", Diff, 0);
    do_op(8'h10, 8'h01, 1'b0);
    chk_res("after_rst", {1'b0, 1'b0, 1'b0, 8'h0F});

    // Sweep
    sa = 8'h03; sb = 8'h00; sbin = 1'b0;
    for (int k = 0; k < 64; k++) begin
      do_op(sa, sb, sbin);
      chk_res($sformatf("sweep%0d", k), model(sa, sb, sbin));
      sa = sa + 8'd4; sb = sb + 8'd7; sbin = ~sbin;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
